control_sequencer: RTL and testbench

//  Hardwired control unit that drives the datapath's control inputs, replacing hand-sequenced bench stimulus.

---
 rtl/control_sequencer.sv | 263 ++++++++++++++++++++++++++
 tb/tb_control_sequencer.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/control_sequencer.sv
// Hardwired control unit: common fetch T0-T2, per-opcode execute T3-T7, then back to T0.
// Optional single-step pause after each instruction is enabled by defining CU_SINGLE_STEP_EN.
module control_sequencer #(
  parameter int                  OPCODE_W    = 5,
  parameter logic [OPCODE_W-1:0] HALT_OPCODE = 5'b11010
) (
  input  logic                Clock,
  input  logic                Clear,
  input  logic [31:0]         IR,
  input  logic                CON_FF,
  input  logic                Step,
  output logic [9:0]          drive,
  output logic [11:0]         load,
  output logic [2:0]          gsel,
  output logic                BAout,
  output logic                IncPC,
  output logic                MDR_read,
  output logic                RAM_write,
  output logic [OPCODE_W-1:0] ALU_op,
  output logic                Run
);

  typedef enum logic [3:0] {
    ST_RESET = 4'd0,
    ST_T0    = 4'd1,
    ST_T1    = 4'd2,
    ST_T2    = 4'd3,
    ST_T3    = 4'd4,
    ST_T4    = 4'd5,
    ST_T5    = 4'd6,
    ST_T6    = 4'd7,
    ST_T7    = 4'd8,
    ST_HALT  = 4'd9,
    ST_WAIT  = 4'd10
  } state_t;

  // Opcode map (IR[31:27])
  localparam logic [OPCODE_W-1:0] OP_LDW  = OPCODE_W'(0);
  localparam logic [OPCODE_W-1:0] OP_LDWI = OPCODE_W'(1);
  localparam logic [OPCODE_W-1:0] OP_STW  = OPCODE_W'(2);
  localparam logic [OPCODE_W-1:0] OP_ADD  = OPCODE_W'(3);
  localparam logic [OPCODE_W-1:0] OP_SUB  = OPCODE_W'(4);
  localparam logic [OPCODE_W-1:0] OP_SHR  = OPCODE_W'(5);
  localparam logic [OPCODE_W-1:0] OP_SHL  = OPCODE_W'(6);
  localparam logic [OPCODE_W-1:0] OP_ROR  = OPCODE_W'(7);
  localparam logic [OPCODE_W-1:0] OP_ROL  = OPCODE_W'(8);
  localparam logic [OPCODE_W-1:0] OP_AND  = OPCODE_W'(9);
  localparam logic [OPCODE_W-1:0] OP_OR   = OPCODE_W'(10);
  localparam logic [OPCODE_W-1:0] OP_ADDI = OPCODE_W'(11);
  localparam logic [OPCODE_W-1:0] OP_ANDI = OPCODE_W'(12);
  localparam logic [OPCODE_W-1:0] OP_ORI  = OPCODE_W'(13);
  localparam logic [OPCODE_W-1:0] OP_MUL  = OPCODE_W'(14);
  localparam logic [OPCODE_W-1:0] OP_DIV  = OPCODE_W'(15);
  localparam logic [OPCODE_W-1:0] OP_NEG  = OPCODE_W'(16);
  localparam logic [OPCODE_W-1:0] OP_NOT  = OPCODE_W'(17);
  localparam logic [OPCODE_W-1:0] OP_BR   = OPCODE_W'(18);
  localparam logic [OPCODE_W-1:0] OP_JR   = OPCODE_W'(19);
  localparam logic [OPCODE_W-1:0] OP_JAL  = OPCODE_W'(20);
  localparam logic [OPCODE_W-1:0] OP_IN   = OPCODE_W'(21);
  localparam logic [OPCODE_W-1:0] OP_OUT  = OPCODE_W'(22);
  localparam logic [OPCODE_W-1:0] OP_MFHI = OPCODE_W'(23);
  localparam logic [OPCODE_W-1:0] OP_MFLO = OPCODE_W'(24);
  localparam logic [OPCODE_W-1:0] ALU_ADD = OPCODE_W'(3);

  // Bit positions inside drive / load / gsel
  localparam int D_PC = 0, D_MDR = 1, D_ZLO = 2, D_ZHI = 3, D_HI = 4;
  localparam int D_LO = 5, D_IN = 6, D_C = 7, D_R = 8;
  localparam int L_MAR = 0, L_MDR = 1, L_PC = 2, L_IR = 3, L_Y = 4, L_ZLO = 5;
  localparam int L_ZHI = 6, L_LO = 7, L_HI = 8, L_OUT = 9, L_CON = 10, L_RIN = 11;
  localparam int G_C = 0, G_B = 1, G_A = 2;

`ifdef CU_SINGLE_STEP_EN
  localparam state_t ST_END = ST_WAIT;
`else
  localparam state_t ST_END = ST_T0;
`endif

  state_t                r_state;
  logic [OPCODE_W-1:0]   w_opcode;
  logic [9:0]            w_drive;
  logic [11:0]           w_load;
  logic [2:0]            w_gsel;
  logic                  w_baout, w_incpc, w_mdr_read, w_ram_write, w_run, w_last;
  logic [OPCODE_W-1:0]   w_alu_op;
  logic                  w_unused_bits;

  assign w_opcode      = IR[31 -: OPCODE_W];
  assign w_unused_bits = ^{Step, IR[31-OPCODE_W:0]};

  // Outputs decode from state and the live IR opcode, since IR only becomes valid in T3.
  always_comb begin
    w_drive     = '0;
    w_load      = '0;
    w_gsel      = '0;
    w_baout     = 1'b0;
    w_incpc     = 1'b0;
    w_mdr_read  = 1'b0;
    w_ram_write = 1'b0;
    w_alu_op    = '0;
    w_run       = 1'b1;
    w_last      = 1'b0;
    case (r_state)
      ST_T0: begin
        w_drive[D_PC] = 1'b1; w_load[L_MAR] = 1'b1; w_incpc = 1'b1; w_load[L_ZLO] = 1'b1;
      end
      ST_T1: begin
        w_drive[D_ZLO] = 1'b1; w_load[L_PC] = 1'b1; w_mdr_read = 1'b1; w_load[L_MDR] = 1'b1;
      end
      ST_T2: begin
        w_drive[D_MDR] = 1'b1; w_load[L_IR] = 1'b1;
      end
      ST_T3: begin
        case (w_opcode)
          OP_LDW, OP_LDWI, OP_STW: begin
            w_gsel[G_B] = 1'b1; w_baout = 1'b1; w_load[L_Y] = 1'b1;
          end
          OP_ADD, OP_SUB, OP_SHR, OP_SHL, OP_ROR, OP_ROL, OP_AND, OP_OR,
          OP_ADDI, OP_ANDI, OP_ORI, OP_MUL, OP_DIV: begin
            w_gsel[G_B] = 1'b1; w_drive[D_R] = 1'b1; w_load[L_Y] = 1'b1;
          end
          OP_NEG, OP_NOT: begin
            w_gsel[G_B] = 1'b1; w_drive[D_R] = 1'b1; w_alu_op = w_opcode; w_load[L_ZLO] = 1'b1;
          end
          OP_BR: begin
            w_gsel[G_A] = 1'b1; w_drive[D_R] = 1'b1; w_load[L_CON] = 1'b1;
          end
          OP_JR: begin
            w_gsel[G_A] = 1'b1; w_drive[D_R] = 1'b1; w_load[L_PC] = 1'b1; w_last = 1'b1;
          end
          OP_JAL: begin
            w_drive[D_PC] = 1'b1; w_gsel[G_B] = 1'b1; w_load[L_RIN] = 1'b1;
          end
          OP_IN: begin
            w_drive[D_IN] = 1'b1; w_gsel[G_A] = 1'b1; w_load[L_RIN] = 1'b1; w_last = 1'b1;
          end
          OP_OUT: begin
            w_gsel[G_A] = 1'b1; w_drive[D_R] = 1'b1; w_load[L_OUT] = 1'b1; w_last = 1'b1;
          end
          OP_MFHI: begin
            w_drive[D_HI] = 1'b1; w_gsel[G_A] = 1'b1; w_load[L_RIN] = 1'b1; w_last = 1'b1;
          end
          OP_MFLO: begin
            w_drive[D_LO] = 1'b1; w_gsel[G_A] = 1'b1; w_load[L_RIN] = 1'b1; w_last = 1'b1;
          end
          default: w_last = 1'b1;
        endcase
      end
      ST_T4: begin
        case (w_opcode)
          OP_LDW, OP_LDWI, OP_STW: begin
            w_drive[D_C] = 1'b1; w_alu_op = ALU_ADD; w_load[L_ZLO] = 1'b1;
          end
          OP_ADD, OP_SUB, OP_SHR, OP_SHL, OP_ROR, OP_ROL, OP_AND, OP_OR: begin
            w_gsel[G_C] = 1'b1; w_drive[D_R] = 1'b1; w_alu_op = w_opcode; w_load[L_ZLO] = 1'b1;
          end
          OP_ADDI, OP_ANDI, OP_ORI: begin
            w_drive[D_C] = 1'b1; w_alu_op = w_opcode; w_load[L_ZLO] = 1'b1;
          end
          OP_MUL, OP_DIV: begin
            w_gsel[G_C] = 1'b1; w_drive[D_R] = 1'b1; w_alu_op = w_opcode;
            w_load[L_ZHI] = 1'b1; w_load[L_ZLO] = 1'b1;
          end
          OP_NEG, OP_NOT: begin
            w_drive[D_ZLO] = 1'b1; w_gsel[G_A] = 1'b1; w_load[L_RIN] = 1'b1; w_last = 1'b1;
          end
          OP_BR: begin
            w_drive[D_PC] = 1'b1; w_load[L_Y] = 1'b1;
          end
          OP_JAL: begin
            w_gsel[G_A] = 1'b1; w_drive[D_R] = 1'b1; w_load[L_PC] = 1'b1; w_last = 1'b1;
          end
          default: w_last = 1'b1;
        endcase
      end
      ST_T5: begin
        case (w_opcode)
          OP_LDW, OP_STW: begin
            w_drive[D_ZLO] = 1'b1; w_load[L_MAR] = 1'b1;
          end
          OP_LDWI, OP_ADD, OP_SUB, OP_SHR, OP_SHL, OP_ROR, OP_ROL, OP_AND, OP_OR,
          OP_ADDI, OP_ANDI, OP_ORI: begin
            w_drive[D_ZLO] = 1'b1; w_gsel[G_A] = 1'b1; w_load[L_RIN] = 1'b1; w_last = 1'b1;
          end
          OP_MUL, OP_DIV: begin
            w_drive[D_ZLO] = 1'b1; w_load[L_LO] = 1'b1;
          end
          OP_BR: begin
            w_drive[D_C] = 1'b1; w_alu_op = ALU_ADD; w_load[L_ZLO] = 1'b1;
          end
          default: w_last = 1'b1;
        endcase
      end
      ST_T6: begin
        case (w_opcode)
          OP_LDW: begin
            w_mdr_read = 1'b1; w_load[L_MDR] = 1'b1;
          end
          OP_STW: begin
            w_gsel[G_A] = 1'b1; w_drive[D_R] = 1'b1; w_load[L_MDR] = 1'b1;
          end
          OP_MUL, OP_DIV: begin
            w_drive[D_ZHI] = 1'b1; w_load[L_HI] = 1'b1; w_last = 1'b1;
          end
          OP_BR: begin
            w_drive[D_ZLO] = 1'b1; w_load[L_PC] = CON_FF; w_last = 1'b1;
          end
          default: w_last = 1'b1;
        endcase
      end
      ST_T7: begin
        w_last = 1'b1;
        case (w_opcode)
          OP_LDW: begin
            w_drive[D_MDR] = 1'b1; w_gsel[G_A] = 1'b1; w_load[L_RIN] = 1'b1;
          end
          OP_STW:  w_ram_write = 1'b1;
          default: ;
        endcase
      end
      ST_HALT: w_run = 1'b0;
      default: ;
    endcase
  end

  // Sequencer state; unused encodings fall back to RESET.
  always_ff @(posedge Clock) begin
    if (Clear) begin
      r_state <= ST_RESET;
    end else begin
      case (r_state)
        ST_RESET: r_state <= ST_T0;
        ST_T0:    r_state <= ST_T1;
        ST_T1:    r_state <= ST_T2;
        ST_T2:    r_state <= ST_T3;
        ST_T3: begin
          if (w_opcode == HALT_OPCODE) r_state <= ST_HALT;
          else if (w_last)             r_state <= ST_END;
          else                         r_state <= ST_T4;
        end
        ST_T4:    r_state <= w_last ? ST_END : ST_T5;
        ST_T5:    r_state <= w_last ? ST_END : ST_T6;
        ST_T6:    r_state <= w_last ? ST_END : ST_T7;
        ST_T7:    r_state <= ST_END;
        ST_HALT:  r_state <= ST_HALT;
`ifdef CU_SINGLE_STEP_EN
        ST_WAIT:  r_state <= Step ? ST_T0 : ST_WAIT;
`endif
        default:  r_state <= ST_RESET;
      endcase
    end
  end

  assign drive     = w_drive;
  assign load      = w_load;
  assign gsel      = w_gsel;
  assign BAout     = w_baout;
  assign IncPC     = w_incpc;
  assign MDR_read  = w_mdr_read;
  assign RAM_write = w_ram_write;
  assign ALU_op    = w_alu_op;
  assign Run       = w_run;

endmodule

// File: tb/tb_control_sequencer.sv
// Directed bench for control_sequencer: fetch, ldwi, add, mul, branch, nop/undefined, ldw abort, halt.
module tb_control_sequencer;

  logic        clk = 1'b0;
  logic        clear, con_ff, step;
  logic [31:0] ir;
  logic [9:0]  drive;
  logic [11:0] load;
  logic [2:0]  gsel;
  logic        baout, incpc, mdr_read, ram_write, run;
  logic [4:0]  alu_op;
  logic [34:0] obs;
  int          total = 0;
  int          bad   = 0;

  localparam logic [9:0]  D0 = 10'h000, D_PC = 10'h001, D_MDR = 10'h002, D_ZLO = 10'h004,
                          D_ZHI = 10'h008, D_C = 10'h080, D_R = 10'h100;
  localparam logic [11:0] L0 = 12'h000, L_MAR = 12'h001, L_MDR = 12'h002, L_PC = 12'h004,
                          L_IR = 12'h008, L_Y = 12'h010, L_ZLO = 12'h020, L_ZHI = 12'h040,
                          L_LO = 12'h080, L_HI = 12'h100, L_CON = 12'h400, L_RIN = 12'h800;
  localparam logic [2:0]  G0 = 3'b000, G_A = 3'b100, G_B = 3'b010, G_C = 3'b001;

  control_sequencer dut (
    .Clock(clk), .Clear(clear), .IR(ir), .CON_FF(con_ff), .Step(step),
    .drive(drive), .load(load), .gsel(gsel), .BAout(baout), .IncPC(incpc),
    .MDR_read(mdr_read), .RAM_write(ram_write), .ALU_op(alu_op), .Run(run)
  );

  always #5 clk = ~clk;

  assign obs = {run, drive, load, gsel, baout, incpc, mdr_read, ram_write, alu_op};

  function automatic logic [34:0] ev(input logic r, input logic [9:0] d, input logic [11:0] l,
                                     input logic [2:0] g, input logic ba, input logic inc,
                                     input logic mrd, input logic rw, input logic [4:0] alu);
    return {r, d, l, g, ba, inc, mrd, rw, alu};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [34:0] e);
    total++;
    assert (obs === e) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, e);
    end
  endtask

  // Caller sits in T0; leaves the sequencer in T3.
  task automatic fetch(input string tag);
    check({tag, "_T0"}, ev(1, D_PC, L_MAR | L_ZLO, G0, 0, 1, 0, 0, 5'd0));
    tick();
    check({tag, "_T1"}, ev(1, D_ZLO, L_PC | L_MDR, G0, 0, 0, 1, 0, 5'd0));
    tick();
    check({tag, "_T2"}, ev(1, D_MDR, L_IR, G0, 0, 0, 0, 0, 5'd0));
    tick();
  endtask

  // Advance past the last execute state; with single-step, exercise WAIT first.
  task automatic finish_instr(input string tag);
    tick();
`ifdef CU_SINGLE_STEP_EN
    check({tag, "_wait0"}, ev(1, D0, L0, G0, 0, 0, 0, 0, 5'd0));
    tick();
    check({tag, "_wait1"}, ev(1, D0, L0, G0, 0, 0, 0, 0, 5'd0));
    step = 1'b1;
    tick();
    step = 1'b0;
`else
    check({tag, "_step_ignored"}, ev(1, D_PC, L_MAR | L_ZLO, G0, 0, 1, 0, 0, 5'd0));
`endif
  endtask

  initial begin
    clear = 1'b1; con_ff = 1'b0; step = 1'b0; ir = 32'h08800007;
    tick();
    check("reset", ev(1, D0, L0, G0, 0, 0, 0, 0, 5'd0));
    clear = 1'b0;
    tick();

    // ldwi r1,7
    fetch("ldwi");
    check("ldwi_T3", ev(1, D0, L_Y, G_B, 1, 0, 0, 0, 5'd0));
    tick();
    check("ldwi_T4", ev(1, D_C, L_ZLO, G0, 0, 0, 0, 0, 5'd3));
    tick();
    check("ldwi_T5", ev(1, D_ZLO, L_RIN, G_A, 0, 0, 0, 0, 5'd0));
    finish_instr("ldwi");

    // add
    ir = 32'h18000000;
    fetch("add");
    check("add_T3", ev(1, D_R, L_Y, G_B, 0, 0, 0, 0, 5'd0));
    tick();
    check("add_T4", ev(1, D_R, L_ZLO, G_C, 0, 0, 0, 0, 5'd3));
    tick();
    check("add_T5", ev(1, D_ZLO, L_RIN, G_A, 0, 0, 0, 0, 5'd0));
    finish_instr("add");

    // mul
    ir = 32'h70000000;
    fetch("mul");
    check("mul_T3", ev(1, D_R, L_Y, G_B, 0, 0, 0, 0, 5'd0));
    tick();
    check("mul_T4", ev(1, D_R, L_ZHI | L_ZLO, G_C, 0, 0, 0, 0, 5'd14));
    tick();
    check("mul_T5", ev(1, D_ZLO, L_LO, G0, 0, 0, 0, 0, 5'd0));
    tick();
    check("mul_T6", ev(1, D_ZHI, L_HI, G0, 0, 0, 0, 0, 5'd0));
    finish_instr("mul");

    // branch, not taken then taken
    ir = 32'h90000000;
    for (int t = 0; t < 2; t++) begin
      con_ff = (t == 1);
      fetch("br");
      check("br_T3", ev(1, D_R, L_CON, G_A, 0, 0, 0, 0, 5'd0));
      tick();
      check("br_T4", ev(1, D_PC, L_Y, G0, 0, 0, 0, 0, 5'd0));
      tick();
      check("br_T5", ev(1, D_C, L_ZLO, G0, 0, 0, 0, 0, 5'd3));
      tick();
      check(t == 1 ? "br_T6_taken" : "br_T6_not_taken",
            ev(1, D_ZLO, (t == 1) ? L_PC : L0, G0, 0, 0, 0, 0, 5'd0));
      finish_instr("br");
    end
    con_ff = 1'b0;

    // nop and an undefined opcode: one silent execute cycle
    ir = 32'hC8000000;
    fetch("nop");
    check("nop_T3", ev(1, D0, L0, G0, 0, 0, 0, 0, 5'd0));
    finish_instr("nop");
    ir = 32'hF8000000;
    fetch("undef");
    check("undef_T3", ev(1, D0, L0, G0, 0, 0, 0, 0, 5'd0));
    finish_instr("undef");

    // ldw aborted by Clear during T4
    ir = 32'h00000000;
    fetch("ldw");
    check("ldw_T3", ev(1, D0, L_Y, G_B, 1, 0, 0, 0, 5'd0));
    tick();
    check("ldw_T4", ev(1, D_C, L_ZLO, G0, 0, 0, 0, 0, 5'd3));
    clear = 1'b1;
    tick();
    check("abort_reset", ev(1, D0, L0, G0, 0, 0, 0, 0, 5'd0));
    clear = 1'b0;
    tick();
    check("abort_T0", ev(1, D_PC, L_MAR | L_ZLO, G0, 0, 1, 0, 0, 5'd0));

    // halt: parks with Run=0 until Clear
    ir = 32'hD0000000;
    fetch("halt");
    check("halt_T3", ev(1, D0, L0, G0, 0, 0, 0, 0, 5'd0));
    step = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      check("halt_hold", ev(0, D0, L0, G0, 0, 0, 0, 0, 5'd0));
    end
    step = 1'b0;
    clear = 1'b1;
    tick();
    check("halt_reset", ev(1, D0, L0, G0, 0, 0, 0, 0, 5'd0));
    clear = 1'b0;
    tick();
    check("halt_T0", ev(1, D_PC, L_MAR | L_ZLO, G0, 0, 1, 0, 0, 5'd0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
